// File: rtl/onehot_decoder_stream.sv
// ---------------------------------------------------------------------------
// onehot_decoder_stream
//
// Purpose:
//   Streams binary indices through a 2-entry FIFO. Each entry is decoded to
//   an 8-bit one-hot word on acceptance, or to 8'h00 when in_en is low.
//   Every word delivered downstream is OR-ed into an accumulator, and a
//   saturating counter (max 15) tracks how many words were delivered.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous active-high reset; clears all state immediately
//   in_valid   upstream offers in_idx/in_en this cycle
//   in_ready   block can accept an entry (registered, occupancy < 2)
//   in_idx     binary index 0..7 to decode
//   in_en      1: decode in_idx; 0: entry decodes to 8'h00
//   out_valid  out_onehot holds a valid entry (registered, occupancy > 0)
//   out_ready  downstream accepts the entry this cycle
//   out_onehot head-of-FIFO word; 8'h00 whenever out_valid is low
//   clr_accum  synchronous clear of accum and count
//   accum      OR of all words delivered since reset/clear
//   count      number of delivered words, saturating at 15
// ---------------------------------------------------------------------------
module onehot_decoder_stream (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_idx,
    input  logic       in_en,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_onehot,
    input  logic       clr_accum,
    output logic [7:0] accum,
    output logic [3:0] count
);

    localparam int DEPTH = 2;

    // FIFO storage and pointers
    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] occ_q, occ_d;

    // Registered handshake/status outputs
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_onehot_q, out_onehot_d;

    // Accumulator and delivery counter
    logic [7:0] accum_q, accum_d;
    logic [3:0] count_q, count_d;

    logic       push;
    logic       pop;
    logic [7:0] in_word;
    logic [3:0] count_inc;

    // Handshakes are qualified only by registered ready/valid, so neither
    // in_ready nor out_valid has a combinational path from the far side.
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        in_word = 8'h00;
        if (in_en) begin
            in_word[in_idx] = 1'b1;
        end
    end

    // Per-entry write enable; only the slot under the write pointer changes.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem_next
            assign mem_d[gi] = (push && (wr_ptr_q == 1'(gi))) ? in_word : mem_q[gi];
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;

        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        in_ready_d  = (occ_d < 2'd2);
        out_valid_d = (occ_d != 2'd0);
        // Next head comes from the next-state memory so that a word pushed
        // into an empty (or just-drained) FIFO appears one cycle later.
        out_onehot_d = out_valid_d ? mem_d[rd_ptr_d] : 8'h00;
    end

    assign count_inc = (count_q == 4'd15) ? 4'd15 : count_q + 4'd1;

    always_comb begin
        accum_d = accum_q;
        count_d = count_q;
        if (clr_accum) begin
            // A clear coinciding with a delivery restarts from that delivery.
            accum_d = pop ? out_onehot_q : 8'h00;
            count_d = pop ? 4'd1 : 4'd0;
        end else if (pop) begin
            accum_d = accum_q | out_onehot_q;
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            occ_q        <= 2'd0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_onehot_q <= 8'h00;
            accum_q      <= 8'h00;
            count_q      <= 4'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            accum_q      <= accum_d;
            count_q      <= count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign accum      = accum_q;
    assign count      = count_q;

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// ---------------------------------------------------------------------------
// tb_onehot_decoder_stream
//
// Scoreboard bench. The driver changes inputs 1ns after each rising edge.
// The monitor looks at the DUT on every falling edge: it compares the DUT's
// status and head word against a reference model (a queue of expected words
// plus an accumulator and counter), then applies the handshakes that the
// next rising edge will perform to that model.
// ---------------------------------------------------------------------------
module tb_onehot_decoder_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_idx;
    logic       in_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_onehot;
    logic       clr_accum;
    logic [7:0] accum;
    logic [3:0] count;

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [7:0] exp_q[$];
    logic [7:0] m_accum = 8'h00;
    int         m_count = 0;

    onehot_decoder_stream dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .clr_accum  (clr_accum),
        .accum      (accum),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic [7:0] head;
        int         size;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                m_accum = 8'h00;
                m_count = 0;
                check("rst_out_valid", int'(out_valid), 0);
                check("rst_in_ready", int'(in_ready), 1);
                check("rst_out_onehot", int'(out_onehot), 0);
                check("rst_accum", int'(accum), 0);
                check("rst_count", int'(count), 0);
            end else begin
                size = exp_q.size();
                check("in_ready", int'(in_ready), (size < 2) ? 1 : 0);
                check("out_valid", int'(out_valid), (size > 0) ? 1 : 0);
                head = (size > 0) ? exp_q[0] : 8'h00;
                check("out_onehot", int'(out_onehot), int'(head));
                check("accum", int'(accum), int'(m_accum));
                check("count", int'(count), m_count);

                if (size > 0 && out_ready) begin
                    void'(exp_q.pop_front());
                    $display("deliver word=0x%02h", head);
                    if (clr_accum) begin
                        m_accum = head;
                        m_count = 1;
                    end else begin
                        m_accum = m_accum | head;
                        m_count = (m_count + 1 > 15) ? 15 : m_count + 1;
                    end
                end else if (clr_accum) begin
                    m_accum = 8'h00;
                    m_count = 0;
                end
                if (in_valid && size < 2) begin
                    exp_q.push_back(in_en ? (8'd1 << in_idx) : 8'h00);
                    $display("accept idx=%0d en=%0d", in_idx, in_en);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] idx, input logic en,
                         input logic ordy, input logic clr);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_idx    = idx;
        in_en     = en;
        out_ready = ordy;
        clr_accum = clr;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Driver
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_idx    = 3'd0;
        in_en     = 1'b0;
        out_ready = 1'b0;
        clr_accum = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // Single entry, held at output
        drive(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
        idle();
        check("lat_out_valid", int'(out_valid), 1);
        check("lat_out_onehot", int'(out_onehot), 8'h20);
        check("lat_in_ready", int'(in_ready), 1);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Fill to two, third offer ignored, then drain
        drive(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        check("full_in_ready", int'(in_ready), 0);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        idle();
        check("fill_accum", int'(accum), 8'h84);
        check("fill_count", int'(count), 2);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Continuous stream 0..7
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 1'b1, 1'b1, 1'b0);
        end
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        idle();
        check("stream_accum", int'(accum), 8'hFF);
        check("stream_count", int'(count), 8);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Disabled entry, then saturation
        drive(1'b1, 3'd3, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        idle();
        check("zero_accum", int'(accum), 8'h00);
        check("zero_count", int'(count), 1);
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 1'b1, 1'b1, 1'b0);
        end
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        idle();
        check("sat_count", int'(count), 15);

        // Clear coincident with delivery of idx 1
        drive(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        idle();
        check("clrpop_accum", int'(accum), 8'h02);
        check("clrpop_count", int'(count), 1);

        // Asynchronous reset with two entries queued
        drive(1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_accum", int'(accum), 0);
        check("arst_count", int'(count), 0);
        @(posedge clk);
        #3 reset = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        idle();
        check("arst_no_stale", int'(out_valid), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 99) < 80), 1'($urandom_range(0, 99) < 55),
                  1'($urandom_range(0, 99) < 4));
        end
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        check("drained", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
